// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//   Receive side of a VGA timing stream (HS / VS / blank). Measures the line
//   and frame periods, locks once LockFrames consecutive frames have been
//   fault free, and regenerates line/column coordinates plus a pixel-valid
//   strobe for a capture path.
//
// Ports
//   clk, rst        pixel clock, asynchronous active-high reset
//   horizontalSync  HS from the generator (polarity set by SyncActive)
//   verticalSync    VS from the generator (polarity set by SyncActive)
//   blank           1 = active video
//   column, line    recovered coordinates of the sample taken 2 clocks ago
//   pixelValid      locked and that sample was an active pixel
//   frameStart      one-cycle pulse per VS leading edge
//   locked          timing verified for LockFrames frames
//   syncError       one-cycle pulse when a locked stream breaks timing
//   hPeriod         last measured line period (clocks)
//   vPeriod         last measured frame period (lines)
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int HActive    = 640,
  parameter int HTotal     = 800,
  parameter int VActive    = 480,
  parameter int VTotal     = 525,
  parameter int LockFrames = 2,
  parameter bit SyncActive = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        horizontalSync,
  input  logic        verticalSync,
  input  logic        blank,
  output logic [9:0]  column,
  output logic [8:0]  line,
  output logic        pixelValid,
  output logic        frameStart,
  output logic        locked,
  output logic        syncError,
  output logic [10:0] hPeriod,
  output logic [9:0]  vPeriod
);

  localparam logic [10:0] HMAX      = 11'd2047;
  localparam logic [9:0]  VMAX      = 10'd1023;
  localparam logic [11:0] HTOT      = 12'(HTotal);
  localparam logic [9:0]  VTOT      = 10'(VTotal);
  localparam logic [9:0]  COL_LAST  = 10'(HActive - 1);
  localparam logic [8:0]  LINE_LAST = 9'(VActive - 1);
  localparam logic [9:0]  COL_END   = 10'(HActive);
  localparam logic [8:0]  LINE_END  = 9'(VActive);
  localparam logic [2:0]  LOCK_N    = 3'(LockFrames);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_LOCK
  } state_t;

  state_t      state;

  // two-stage input history; s1 is the sample being processed, s2 the one before
  logic        hs_s1, hs_s2, vs_s1, vs_s2, bl_s1, bl_s2;

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [2:0]  good_frames;
  logic        frame_fault;   // a fault has been seen in the current MEASURE frame
  logic        h_armed;       // previous HS edge seen since leaving SEARCH -> period is whole
  logic        line_pending;  // next blank rise is line 0 of the frame

  logic        hs_edge, vs_edge, bl_rise;
  logic [11:0] h_next_period;
  logic        h_sat;
  logic        h_fault, v_fault, col_ovf, line_ovf, sat_fault, fault_now;
  logic [9:0]  col_next;
  logic [8:0]  line_next;
  logic        pend_next;

  assign hs_edge = (hs_s1 == SyncActive) && (hs_s2 != SyncActive);
  assign vs_edge = (vs_s1 == SyncActive) && (vs_s2 != SyncActive);
  assign bl_rise = bl_s1 & ~bl_s2;

  assign h_next_period = {1'b0, hcount} + 12'd1;
  assign h_sat         = (hcount == HMAX);

  // fault sources; only acted on outside SEARCH
  assign h_fault   = hs_edge & h_armed & (h_next_period != HTOT);
  assign v_fault   = vs_edge & (vcount != VTOT);
  assign col_ovf   = bl_s1 & bl_s2 & (column == COL_LAST);
  assign line_ovf  = bl_rise & ~(line_pending | vs_edge) & (line == LINE_LAST);
  assign sat_fault = h_sat & ~hs_edge;
  assign fault_now = (state != ST_SEARCH) &
                     (h_fault | v_fault | col_ovf | line_ovf | sat_fault);

  // column: restarts at 0 on each blank rise, holds at the last column on overrun
  always_comb begin
    col_next = '0;
    if (bl_s1) begin
      if (!bl_s2)                 col_next = '0;
      else if (column == COL_LAST) col_next = column;
      else                        col_next = column + 10'd1;
    end
  end

  // line: VS clears it and arms "next active line is 0"; VS is applied before
  // a blank rise landing in the same cycle
  always_comb begin
    line_next = line;
    pend_next = line_pending;
    if (vs_edge) begin
      line_next = '0;
      pend_next = 1'b1;
    end
    if (bl_rise) begin
      if (pend_next) begin
        line_next = '0;
        pend_next = 1'b0;
      end else if (line_next != LINE_LAST) begin
        line_next = line_next + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_s1        <= ~SyncActive;
      hs_s2        <= ~SyncActive;
      vs_s1        <= ~SyncActive;
      vs_s2        <= ~SyncActive;
      bl_s1        <= 1'b0;
      bl_s2        <= 1'b0;
      hcount       <= '0;
      vcount       <= '0;
      good_frames  <= '0;
      frame_fault  <= 1'b0;
      h_armed      <= 1'b0;
      line_pending <= 1'b1;
      state        <= ST_SEARCH;
      column       <= '0;
      line         <= '0;
      pixelValid   <= 1'b0;
      frameStart   <= 1'b0;
      locked       <= 1'b0;
      syncError    <= 1'b0;
      hPeriod      <= '0;
      vPeriod      <= '0;
    end else begin
      hs_s1 <= horizontalSync;
      hs_s2 <= hs_s1;
      vs_s1 <= verticalSync;
      vs_s2 <= vs_s1;
      bl_s1 <= blank;
      bl_s2 <= bl_s1;

      // line period; a saturated count reports as 2047 rather than wrapping
      if (hs_edge) begin
        hcount  <= '0;
        hPeriod <= h_sat ? HMAX : h_next_period[10:0];
      end else if (!h_sat) begin
        hcount <= hcount + 11'd1;
      end

      // frame period; a coincident HS is line 1 of the new frame
      if (vs_edge) begin
        vPeriod <= vcount;
        vcount  <= hs_edge ? 10'd1 : 10'd0;
      end else if (hs_edge && vcount != VMAX) begin
        vcount <= vcount + 10'd1;
      end

      column       <= col_next;
      line         <= line_next;
      line_pending <= pend_next;
      frameStart   <= vs_edge;
      syncError    <= 1'b0;
      pixelValid   <= (state == ST_LOCK) & ~fault_now & bl_s1 &
                      (col_next < COL_END) & (line_next < LINE_END);

      // in SEARCH the next period is whole only if an HS edge lands right now
      h_armed <= (state == ST_SEARCH) ? hs_edge : (h_armed | hs_edge);

      case (state)
        ST_SEARCH: begin
          locked      <= 1'b0;
          frame_fault <= 1'b0;
          good_frames <= '0;
          if (vs_edge) state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          locked <= 1'b0;
          if (vs_edge) begin
            frame_fault <= 1'b0;
            if (frame_fault | fault_now) begin
              good_frames <= '0;
            end else begin
              good_frames <= good_frames + 3'd1;
              if (good_frames + 3'd1 == LOCK_N) begin
                state  <= ST_LOCK;
                locked <= 1'b1;
              end
            end
          end else if (fault_now) begin
            frame_fault <= 1'b1;
          end
        end
        ST_LOCK: begin
          // locked stays high for the syncError cycle and drops in SEARCH
          if (fault_now) begin
            syncError <= 1'b1;
            state     <= ST_SEARCH;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

endmodule
